// File: rtl/channel_scheduler_pkg.sv
// Shared types and helpers for the channel scheduler: FSM state encoding
// and the saturating LLR magnitude used by the bit-to-LLR mapper.
package channel_scheduler_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int FRAME_CNT_W = 16;

    // Largest symmetric magnitude of a BITS-wide two's complement value.
    // The most negative code is excluded so +/- confidence stays symmetric.
    function automatic int llr_mag(input int bits);
        return (1 << (bits - 1)) - 1;
    endfunction

endpackage

// File: rtl/channel_scheduler_llr_map.sv
// Combinational hard-decision to LLR mapper: bit 0 -> +mag, bit 1 -> -mag.
// When en is low every LLR reads as zero (no frame held).
module llr_map
    import channel_scheduler_pkg::*;
#(
    parameter int N    = 8,
    parameter int BITS = 4
) (
    input  logic                     en,
    input  logic [N-1:0]             bits,
    output logic [N-1:0][BITS-1:0]   llr
);

    localparam logic [BITS-1:0] POS_LLR = BITS'(llr_mag(BITS));
    localparam logic [BITS-1:0] NEG_LLR = BITS'(-llr_mag(BITS));

    // Map every held bit to its signed confidence value.
    always_comb begin
        llr = '0;
        for (int i = 0; i < N; i++) begin
            if (en) begin
                llr[i] = bits[i] ? NEG_LLR : POS_LLR;
            end
        end
    end

endmodule

// File: rtl/channel_scheduler.sv
// Round-robin channel scheduler. Requesters offer codeword frames; one is
// granted per IDLE cycle, optionally corrupted by a flip mask, held as hard
// bits and presented downstream as LLRs until the decoder takes it.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. req_ready is combinational (one-hot grant, only in IDLE, never
// during reset). out_valid is held high in HOLD until out_ready is seen;
// out_llr/out_src stay constant for that whole interval.
module channel_scheduler
    import channel_scheduler_pkg::*;
#(
    parameter int BITS = 4,
    parameter int N    = 8,
    parameter int NREQ = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NREQ-1:0]               req_valid,
    input  logic [NREQ-1:0][N-1:0]        req_data,
    output logic [NREQ-1:0]               req_ready,
    input  logic                          flip_en,
    input  logic [N-1:0]                  flip_mask,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [N-1:0][BITS-1:0]        out_llr,
    output logic [$clog2(NREQ)-1:0]       out_src,
    output logic [FRAME_CNT_W-1:0]        frame_cnt,
    output state_t                        fsm_state
);

    localparam int SRC_W = $clog2(NREQ);

    state_t             state;
    logic [N-1:0]       data_q;
    logic [SRC_W-1:0]   rr_ptr;
    logic               grant_found;
    logic [SRC_W-1:0]   grant_idx;
    logic [SRC_W-1:0]   cand;
    logic [SRC_W-1:0]   next_ptr;

    // Rotating priority search: first valid requester at or after rr_ptr.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = SRC_W'((int'(rr_ptr) + k) % NREQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Pointer moves just past the winner so it has lowest priority next time.
    always_comb begin
        next_ptr = (grant_idx == SRC_W'(NREQ - 1)) ? '0 : grant_idx + SRC_W'(1);
    end

    // One-hot ready only for the winner, only while no frame is held.
    always_comb begin
        req_ready = '0;
        if (!rst && state == IDLE && grant_found) begin
            req_ready = NREQ'(1) << grant_idx;
        end
    end

    // Scheduler FSM: capture a frame in IDLE, release it on out_ready in HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            data_q    <= '0;
            out_src   <= '0;
            rr_ptr    <= '0;
            frame_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        data_q  <= req_data[grant_idx] ^ (flip_en ? flip_mask : '0);
                        out_src <= grant_idx;
                        rr_ptr  <= next_ptr;
                        state   <= HOLD;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        frame_cnt <= frame_cnt + 16'd1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign out_valid = (state == HOLD);
    assign fsm_state = state;

    llr_map #(
        .N    (N),
        .BITS (BITS)
    ) u_llr_map (
        .en   (out_valid),
        .bits (data_q),
        .llr  (out_llr)
    );

endmodule

// File: doc/channel_scheduler.md
CHANNEL_SCHEDULER -- requirements
Module: channel_scheduler

Interface
REQ-001 Parameter BITS, default 4, LLR width in bits, two's complement.
REQ-002 Parameter N, default 8, codeword length in bits.
REQ-003 Parameter NREQ, default 2, number of requesters sharing the channel; legal range 2..4.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 req_valid  input  [NREQ]  requester i has a codeword frame pending.
REQ-007 req_data  input  [NREQ][N] x 1  codeword bits of requester i, stable while req_valid[i].
REQ-008 req_ready  output  [NREQ]  one-hot; frame of requester i is accepted this cycle.
REQ-009 flip_en  input  1  error injection enable, sampled in the accept cycle.
REQ-010 flip_mask  input  [N] x 1  bit positions to invert when flip_en=1.
REQ-011 out_valid  output  1  out_llr/out_src hold a valid frame.
REQ-012 out_ready  input  1  downstream decoder accepts the frame.
REQ-013 out_llr  output  [N] x [BITS-1:0]  per-bit LLR of the held frame.
REQ-014 out_src  output  clog2(NREQ)  index of the requester that owns the held frame.
REQ-015 frame_cnt  output  16  count of frames delivered downstream.

Function
REQ-016 The FSM SHALL have two states: IDLE (no frame held) and HOLD (frame held, out_valid=1).
REQ-017 In IDLE with any req_valid high, the block SHALL grant round-robin, starting search at pointer rr_ptr and wrapping past NREQ-1 to 0.
REQ-018 req_ready SHALL be combinational, high only for the granted index, only in IDLE, and all zero otherwise.
REQ-019 On the accept edge the block SHALL capture data = req_data[g] XOR (flip_en ? flip_mask : 0), set out_src=g, set rr_ptr=(g+1) mod NREQ, and enter HOLD.
REQ-020 The LLR of a captured bit SHALL be +(2**(BITS-1)-1) for bit 0 and -(2**(BITS-1)-1) for bit 1 (BITS=4: 7 and -7 (4'b1001)); -2**(BITS-1) is never produced.
REQ-021 out_valid SHALL rise the cycle after acceptance (latency 1); out_llr/out_src SHALL stay constant while in HOLD.
REQ-022 In HOLD with out_ready=1, the block SHALL return to IDLE and increment frame_cnt by 1, wrapping 16'hFFFF to 0.
REQ-023 req_valid changes during HOLD SHALL be ignored; no requester is accepted until IDLE; peak throughput is one frame per 2 cycles.
REQ-024 out_ready in IDLE SHALL have no effect.
REQ-025 A requester dropping req_valid before grant SHALL lose its turn with no state change.

Reset
REQ-026 rst SHALL force IDLE, out_valid=0, req_ready=0, out_llr all 0, out_src=0, rr_ptr=0, frame_cnt=0.
REQ-027 rst asserted in HOLD SHALL discard the held frame without incrementing frame_cnt; rst overrides every concurrent handshake.

Structure
REQ-028 A shared package SHALL hold the state enum (IDLE, HOLD) and the LLR magnitude function of BITS.
REQ-029 Bit-to-LLR mapping SHALL be a combinational sub-module llr_map (N bits in, N LLRs out); the scheduler holds registered bits only.

Verification
REQ-030 Single frame: req_valid[0]=1, req_data[0]=8'b0000_0001, flip_en=0 -> req_ready[0] one cycle, next cycle out_valid=1, out_llr[0]=-7, out_llr[1..7]=7, out_src=0.
REQ-031 Fairness: both req_valid held high, out_ready=1 -> grants alternate 0,1,0,1; out_src sequence 0,1,0,1; frame_cnt=4 after 8 cycles.
REQ-032 Backpressure: out_ready=0 for 5 cycles in HOLD -> out_llr stable, req_ready all 0, frame_cnt unchanged; first out_ready=1 -> frame_cnt+1, IDLE.
REQ-033 Injection: req_data=8'h00, flip_en=1, flip_mask=8'hA5 -> bits 0,2,5,7 give -7, others 7.
REQ-034 Reset mid-HOLD: rst in HOLD -> next cycle out_valid=0, frame_cnt unchanged, rr_ptr=0 so requester 0 wins the next tie.
REQ-035 Wrap: preload via 65536 delivered frames -> frame_cnt returns to 0.
